parity_burst_sequencer: RTL
===========================

PARITY_BURST_SEQUENCER -- requirements
Module: parity_burst_sequencer

Interface
REQ-001 Parameter LEN_W, default 4, sets the width of the burst-length field and the step counter.
REQ-002 Parameter GAP_W, default 2, sets the width of the inter-step idle-gap field.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  synchronous, active-low reset (0 = reset), sampled on rising clk.
REQ-005 cmd_valid  input  1  command present.
REQ-006 cmd_ready  output  1  sequencer can accept a command; high only in IDLE.
REQ-007 cmd_parity  input  1  start parity: 0 = even (start 0), 1 = odd (start 1).
REQ-008 cmd_len  input  LEN_W  number of +2 steps to issue, 0..15.
REQ-009 cmd_gap  input  GAP_W  idle cycles inserted after each step, 0..3.
REQ-010 abort  input  1  terminate the current burst.
REQ-011 cnt_in  input  4  count value returned by the downstream step-by-2 counter.
REQ-012 ctr_rst  output  1  active-high load strobe to the counter.
REQ-013 ctr_odd_even  output  1  parity select to the counter.
REQ-014 ctr_enable  output  1  one-cycle step strobe to the counter.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 done  output  1  one-cycle pulse on normal burst completion.
REQ-017 aborted  output  1  one-cycle pulse when a burst is terminated by abort.
REQ-018 seq_err  output  1  sticky: cnt_in diverged from the expected value.

Function
REQ-019 The FSM SHALL have states IDLE, LOAD, RUN, GAP and DONE.
REQ-020 A command SHALL be accepted when cmd_valid and cmd_ready are both high; cmd_parity, cmd_len and cmd_gap are latched; the next state is LOAD.
REQ-021 LOAD SHALL last one cycle with ctr_rst=1 and ctr_odd_even=latched parity; the next state is RUN, or DONE if len=0.
REQ-022 RUN SHALL last one cycle with ctr_enable=1 and SHALL increment the step counter.
REQ-023 After RUN: if steps issued = len, go to DONE; else if gap>0, go to GAP for exactly gap cycles and then to RUN; else go to RUN again, giving back-to-back enables.
REQ-024 DONE SHALL last one cycle with done=1; the next state is IDLE, and a new command is accepted no earlier than the cycle after DONE.
REQ-025 ctr_odd_even SHALL hold the latched parity from LOAD until the next command is accepted.
REQ-026 All outputs SHALL be decoded from registered state only, with no combinational path from any input to any output.
REQ-027 Expected count exp (4 bit) SHALL load {3'b0, parity} in LOAD and add 2 mod 16 on every cycle with ctr_enable=1; wrap 14→0 and 15→1 is legal.
REQ-028 In RUN, GAP and DONE, cnt_in != exp SHALL set seq_err; seq_err clears only when a command is accepted or on reset.
REQ-029 abort=1 in LOAD, RUN or GAP SHALL force the next state to IDLE with aborted=1 for that next cycle, and no further ctr_enable is issued.
REQ-030 abort in IDLE or DONE SHALL be ignored; DONE completes normally.
REQ-031 When abort and the final step coincide, abort SHALL take priority: aborted=1 and done=0.
REQ-032 Total burst latency from the accept edge to the done pulse SHALL be 2 + len×(1+gap) − gap cycles for len≥1, and 2 cycles for len=0.

Reset
REQ-033 With rst=0 at a rising edge, the state SHALL be IDLE; ctr_rst, ctr_enable, ctr_odd_even, done, aborted, seq_err and busy SHALL be 0; cmd_ready SHALL be 1 from the cycle after rst returns to 1.
REQ-034 Reset mid-burst SHALL abandon the burst without asserting the done or aborted pulse.

Structure
REQ-035 The state encoding and the LEN_W/GAP_W defaults SHALL live in the shared package parity_seq_pkg.
REQ-036 The gap countdown SHALL be a sub-module seq_gap_timer (load, tick, expire).

Verification
REQ-037 Even burst: parity=0, len=3, gap=0 with a model counter → enables in 3 consecutive cycles, cnt_in 0,2,4,6, done 5 cycles after accept, seq_err=0.
REQ-038 Odd burst with gap: parity=1, len=2, gap=2 → enable, 2 idle, enable; cnt_in ends at 5; done at cycle 6.
REQ-039 Wrap: parity=1, len=9, gap=0 → exp wraps 15→1; final cnt_in=3; seq_err=0.
REQ-040 Fault: the model counter skips one enable → seq_err=1 and stays set until the next command is accepted.
REQ-041 Abort during GAP (len=4, gap=3, abort after step 2) → exactly 2 enables, aborted pulse, done=0, cmd_ready=1 on the following cycle.
REQ-042 len=0 and mid-burst rst=0 → len=0 gives LOAD then done with no enable; reset gives all outputs 0 with no pulses.

Source files
------------

// File: rtl/parity_seq_pkg.sv
// Shared definitions for the parity burst sequencer: state encoding,
// default field widths and the expected-count step helper.
package parity_seq_pkg;

  localparam int LEN_W_DEF = 4;
  localparam int GAP_W_DEF = 2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_RUN  = 3'd2,
    ST_GAP  = 3'd3,
    ST_DONE = 3'd4
  } seq_state_e;

  // The downstream counter steps by two and wraps modulo 16.
  function automatic logic [3:0] exp_step(input logic [3:0] v);
    return v + 4'd2;
  endfunction

endpackage

// File: rtl/seq_gap_timer.sv
// Idle-gap countdown: load with the gap length, tick once per gap cycle,
// expire flags the last gap cycle.
module seq_gap_timer #(
  parameter int GAP_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [GAP_W-1:0] load_val,
  input  logic             tick,
  output logic             expire
);

  logic [GAP_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (tick && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire = (count_q == GAP_W'(1));

endmodule

// File: rtl/parity_burst_sequencer.sv
// Issues a burst of step strobes to an external step-by-2 counter and checks
// the returned count against an internally tracked expected value.
module parity_burst_sequencer
  import parity_seq_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEF,
  parameter int GAP_W = GAP_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_parity,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [GAP_W-1:0] cmd_gap,
  input  logic             abort,
  input  logic [3:0]       cnt_in,
  output logic             ctr_rst,
  output logic             ctr_odd_even,
  output logic             ctr_enable,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             seq_err
);

  seq_state_e       state_q, state_d;
  logic             parity_q, parity_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [LEN_W-1:0] step_q, step_d;
  logic [3:0]       exp_q, exp_d;
  logic             seq_err_q, seq_err_d;
  logic             aborted_q, aborted_d;
  logic             gap_load, gap_tick, gap_expire;

  seq_gap_timer #(.GAP_W(GAP_W)) u_gap_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (gap_load),
    .load_val (gap_q),
    .tick     (gap_tick),
    .expire   (gap_expire)
  );

  always_comb begin
    state_d   = state_q;
    parity_d  = parity_q;
    len_d     = len_q;
    gap_d     = gap_q;
    step_d    = step_q;
    exp_d     = exp_q;
    seq_err_d = seq_err_q;
    aborted_d = 1'b0;
    gap_load  = 1'b0;
    gap_tick  = 1'b0;

    // The counter value is only meaningful once LOAD has taken effect.
    if ((state_q == ST_RUN || state_q == ST_GAP || state_q == ST_DONE) && (cnt_in != exp_q)) begin
      seq_err_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          parity_d  = cmd_parity;
          len_d     = cmd_len;
          gap_d     = cmd_gap;
          step_d    = '0;
          seq_err_d = 1'b0;
          state_d   = ST_LOAD;
        end
      end
      ST_LOAD: begin
        exp_d = {3'b000, parity_q};
        if (abort) begin
          state_d   = ST_IDLE;
          aborted_d = 1'b1;
        end else if (len_q == '0) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        step_d = step_q + 1'b1;
        exp_d  = exp_step(exp_q);
        // Abort outranks completion of the final step.
        if (abort) begin
          state_d   = ST_IDLE;
          aborted_d = 1'b1;
        end else if (step_d == len_q) begin
          state_d = ST_DONE;
        end else if (gap_q != '0) begin
          state_d  = ST_GAP;
          gap_load = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_GAP: begin
        gap_tick = 1'b1;
        if (abort) begin
          state_d   = ST_IDLE;
          aborted_d = 1'b1;
        end else if (gap_expire) begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      parity_q  <= 1'b0;
      len_q     <= '0;
      gap_q     <= '0;
      step_q    <= '0;
      exp_q     <= 4'd0;
      seq_err_q <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      parity_q  <= parity_d;
      len_q     <= len_d;
      gap_q     <= gap_d;
      step_q    <= step_d;
      exp_q     <= exp_d;
      seq_err_q <= seq_err_d;
      aborted_q <= aborted_d;
    end
  end

  assign cmd_ready    = (state_q == ST_IDLE);
  assign busy         = (state_q != ST_IDLE);
  assign ctr_rst      = (state_q == ST_LOAD);
  assign ctr_enable   = (state_q == ST_RUN);
  assign done         = (state_q == ST_DONE);
  assign ctr_odd_even = parity_q;
  assign aborted      = aborted_q;
  assign seq_err      = seq_err_q;

endmodule
